input_fifo_rx: RTL and testbench

Receiving end of the inter-router RTS/DCTS link: accepts flits from an upstream router's output port and buffers them in a small FIFO. Drives the upstream port's DCTS, and presents the head flit to the local crossbar. One instance per input port (N/E/W/S/L). The read side is driven by the downstream arbiters' grants.

---
 rtl/input_fifo_rx.sv | 100 ++++++++++
 tb/tb_input_fifo_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/input_fifo_rx.sv
// Receive side of the RTS/DCTS inter-router link: one-cycle CTS pulse per
// accepted flit, a DEPTH-entry FIFO, and a head flit popped by any output arbiter.

module input_fifo_rx_entry #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    q <= '0;
      else if (we) q <= d;
   end
endmodule

module input_fifo_rx #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int PTR_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  DRTS,
   input  logic [DATA_WIDTH-1:0] RX,
   input  logic                  read_en_N,
   input  logic                  read_en_E,
   input  logic                  read_en_W,
   input  logic                  read_en_S,
   input  logic                  read_en_L,
   output logic                  CTS,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic                  empty,
   output logic                  full
);
   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   localparam logic [PTR_W:0] PTR_ONE = 1;

   state_t                               state_q, state_d;
   logic   [PTR_W:0]                     wr_ptr, rd_ptr;
   logic   [DEPTH-1:0][DATA_WIDTH-1:0]   mem_q;
   logic   [DEPTH-1:0]                   mem_we;
   logic                                 push, pop, rd_req;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   // Arbiters guarantee one-hot grants; OR-ing still caps pops at one per cycle.
   assign rd_req = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
   assign pop    = rd_req & ~empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // ACK always returns to IDLE, so a held DRTS yields one flit every two cycles.
   always_comb begin
      state_d = IDLE;
      push    = 1'b0;
      case (state_q)
         IDLE: if (DRTS && !full) begin
            push    = 1'b1;
            state_d = ACK;
         end
         ACK:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign CTS = (state_q == ACK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign mem_we[i] = push && (wr_ptr[PTR_W-1:0] == PTR_W'(i));
      input_fifo_rx_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
         .clk (clk),
         .rst (rst),
         .we  (mem_we[i]),
         .d   (RX),
         .q   (mem_q[i])
      );
   end

   assign Data_out = mem_q[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_input_fifo_rx.sv
// Directed bench for input_fifo_rx: a scoreboard queue records accepted flits
// and each pop compares the head flit against it.

module tb_input_fifo_rx;
   logic        clk = 1'b0;
   logic        run = 1'b0;
   logic        rst;
   logic        DRTS;
   logic [31:0] RX;
   logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
   logic        CTS;
   logic [31:0] Data_out;
   logic        empty, full;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] sb[$];

   input_fifo_rx #(.DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .DRTS      (DRTS),
      .RX        (RX),
      .read_en_N (read_en_N),
      .read_en_E (read_en_E),
      .read_en_W (read_en_W),
      .read_en_S (read_en_S),
      .read_en_L (read_en_L),
      .CTS       (CTS),
      .Data_out  (Data_out),
      .empty     (empty),
      .full      (full)
   );

   always begin
      wait (run);
      #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int port, input logic v);
      case (port)
         0: read_en_N = v;
         1: read_en_E = v;
         2: read_en_W = v;
         3: read_en_S = v;
         default: read_en_L = v;
      endcase
   endtask

   // Sender model: hold RTS until CTS seen, then drop it and let the pulse end.
   task automatic send(input logic [31:0] d);
      DRTS = 1'b1;
      RX   = d;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (CTS) break;
      end
      chk("send_ack", {31'b0, CTS}, 32'd1);
      if (CTS) sb.push_back(d);
      DRTS = 1'b0;
      chk("send_not_empty", {31'b0, empty}, 32'd0);
      tick();
      chk("cts_pulse_end", {31'b0, CTS}, 32'd0);
   endtask

   task automatic pop(input int port);
      logic [31:0] exp;
      exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk("pop_not_empty", {31'b0, empty}, 32'd0);
      chk("pop_data", Data_out, exp);
      set_rd(port, 1'b1);
      tick();
      set_rd(port, 1'b0);
   endtask

   initial begin
      int pulses;
      logic [31:0] v;
      rst = 1'b1; DRTS = 1'b0; RX = '0;
      read_en_N = 0; read_en_E = 0; read_en_W = 0; read_en_S = 0; read_en_L = 0;

      // Asynchronous reset with the clock stopped
      #2 rst = 1'b0;
      #1;
      chk("rst_cts",   {31'b0, CTS},   32'd0);
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_full",  {31'b0, full},  32'd0);
      chk("rst_data",  Data_out,       32'd0);
      #2 rst = 1'b1;
      run = 1'b1;
      tick();

      // Single flit, popped via East
      send(32'hA5A5_0001);
      chk("single_data", Data_out, 32'hA5A5_0001);
      pop(1);
      chk("single_empty", {31'b0, empty}, 32'd1);

      // Fill with DRTS held: flits 1..4 accepted, 5 blocked
      DRTS = 1'b1; v = 32'd1; RX = v; pulses = 0;
      for (int n = 0; n < 12; n++) begin
         tick();
         if (CTS) begin
            pulses++;
            sb.push_back(v);
            v = v + 32'd1;
            RX = v;
         end
      end
      chk("fill_pulses", pulses, 32'd4);
      chk("fill_full",   {31'b0, full}, 32'd1);
      chk("fill_cts",    {31'b0, CTS},  32'd0);

      // Pop via Local while full and DRTS high: refused now, accepted next edge
      pop(4);
      chk("full_pop_cts",  {31'b0, CTS},  32'd0);
      chk("full_pop_full", {31'b0, full}, 32'd0);
      tick();
      chk("fifth_accept", {31'b0, CTS}, 32'd1);
      if (CTS) sb.push_back(RX);
      DRTS = 1'b0;
      tick();
      chk("refill_full", {31'b0, full}, 32'd1);

      // Full + read_en_N + DRTS: pop occurs, no CTS
      DRTS = 1'b1; RX = 32'd6;
      pop(0);
      DRTS = 1'b0;
      chk("simul_full_cts",  {31'b0, CTS},  32'd0);
      chk("simul_full_full", {31'b0, full}, 32'd0);
      tick();
      chk("simul_full_nocap", {31'b0, CTS}, 32'd0);
      while (sb.size() != 0) pop(2);
      chk("drain_empty", {31'b0, empty}, 32'd1);

      // Interleaved push/pop across the pointer wrap
      for (int i = 1; i <= 10; i++) begin
         send(32'(i));
         if (sb.size() >= 2) pop(i % 5);
      end
      while (sb.size() != 0) pop(3);
      chk("wrap_empty", {31'b0, empty}, 32'd1);

      // Empty + read_en_S + DRTS: push happens, pop ignored
      DRTS = 1'b1; RX = 32'h77; read_en_S = 1'b1;
      tick();
      DRTS = 1'b0; read_en_S = 1'b0;
      chk("simul_empty_cts",   {31'b0, CTS},   32'd1);
      chk("simul_empty_empty", {31'b0, empty}, 32'd0);
      if (CTS) sb.push_back(32'h77);
      tick();
      pop(1);
      chk("simul_empty_drain", {31'b0, empty}, 32'd1);

      // Reset mid-operation with three buffered flits and CTS high
      send(32'h31);
      send(32'h32);
      DRTS = 1'b1; RX = 32'h33;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (CTS) break;
      end
      chk("pre_rst_cts", {31'b0, CTS}, 32'd1);
      DRTS = 1'b0;
      rst  = 1'b0;
      #1;
      chk("mid_rst_cts",   {31'b0, CTS},   32'd0);
      chk("mid_rst_empty", {31'b0, empty}, 32'd1);
      chk("mid_rst_data",  Data_out,       32'd0);
      sb.delete();
      #1 rst = 1'b1;
      send(32'hBEEF);
      chk("post_rst_idx0", Data_out, 32'hBEEF);
      pop(0);
      chk("post_rst_empty", {31'b0, empty}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
